dsp_scheduler: RTL and testbench



---
 rtl/audioport_pkg.sv | 24 ++
 rtl/dsp_tick_gen.sv | 52 +++++
 rtl/dsp_scheduler.sv | 129 ++++++++++++
 tb/tb_dsp_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/audioport_pkg.sv
// Shared types and constants for the audioport DSP sequencing logic.
package audioport_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED    = 2'd0,
    ST_RUNNING    = 2'd1,
    ST_PROCESSING = 2'd2
  } dsp_sched_state_t;

  localparam int DSP_LATENCY = 4;

  // Bit positions inside the {clr, cfg, level} pending vector.
  localparam int PEND_CLR   = 2;
  localparam int PEND_CFG   = 1;
  localparam int PEND_LEVEL = 0;

  // The period must leave room for the processing window plus one command slot.
  function automatic logic [31:0] clamp_cdiv(input logic [31:0] cdiv, input int unsigned latency);
    logic [31:0] floor_v;
    floor_v = 32'(latency + 2);
    return (cdiv < floor_v) ? floor_v : cdiv;
  endfunction

endpackage

// File: rtl/dsp_tick_gen.sv
// Sample-rate divider: registered one-cycle tick every eff_cdiv cycles while running.
// tick_next_out is the value tick_out takes at the next edge.
module dsp_tick_gen #(
  parameter int DSP_LATENCY = audioport_pkg::DSP_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_in,
  input  logic        load_in,
  input  logic [31:0] cdiv_in,
  output logic        tick_next_out,
  output logic        tick_out
);
  import audioport_pkg::*;

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] eff_q, eff_d;
  logic        tick_q, tick_d;
  logic        wrap;

  always_comb begin
    wrap   = run_in && (cnt_q == eff_q - 32'd1);
    tick_d = wrap;
    cnt_d  = cnt_q;
    eff_d  = eff_q;
    if (!run_in || wrap) begin
      cnt_d = 32'd0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
    // A new divider value only takes effect at a period boundary.
    if (load_in || wrap) begin
      eff_d = clamp_cdiv(cdiv_in, DSP_LATENCY);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 32'd0;
      eff_q  <= 32'(DSP_LATENCY + 2);
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      eff_q  <= eff_d;
      tick_q <= tick_d;
    end
  end

  assign tick_next_out = tick_d;
  assign tick_out      = tick_q;

endmodule

// File: rtl/dsp_scheduler.sv
// Sequences dsp_unit: sample ticks plus one serialised command per idle cycle (clr > cfg > level).
// Commands requested during a tick's processing window wait until the window closes.
module dsp_scheduler #(
  parameter int DSP_LATENCY = audioport_pkg::DSP_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play_in,
  input  logic [31:0] cdiv_in,
  input  logic        cfg_req_in,
  input  logic        level_req_in,
  input  logic        clr_req_in,
  output logic        tick_out,
  output logic        cfg_out,
  output logic        level_out,
  output logic        clr_out,
  output logic        busy_out,
  output logic [2:0]  pending_out,
  output logic        cfg_err_out
);
  import audioport_pkg::*;

  localparam int WW = $clog2(DSP_LATENCY + 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(DSP_LATENCY);

  dsp_sched_state_t state_q, state_d;

  logic          run, start, tick_d, win_end;
  logic          busy_q, busy_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [2:0]    pend_q, pend_d;
  logic [2:0]    cmd_q, cmd_d;
  logic [2:0]    req;
  logic          err_q, err_d;

  assign run   = play_in && (state_q != ST_STOPPED);
  assign start = play_in && (state_q == ST_STOPPED);

  dsp_tick_gen #(
    .DSP_LATENCY(DSP_LATENCY)
  ) u_tick_gen (
    .clk          (clk),
    .rst          (rst),
    .run_in       (run),
    .load_in      (start),
    .cdiv_in      (cdiv_in),
    .tick_next_out(tick_d),
    .tick_out     (tick_out)
  );

  assign win_end = busy_q && (win_cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_STOPPED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STOPPED: begin
        if (play_in) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (!play_in)    state_d = ST_STOPPED;
        else if (tick_d) state_d = ST_PROCESSING;
      end
      ST_PROCESSING: begin
        if (win_end) state_d = play_in ? ST_RUNNING : ST_STOPPED;
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  always_comb begin
    busy_d    = tick_d || (busy_q && (win_cnt_q != '0));
    win_cnt_d = '0;
    if (tick_d) begin
      win_cnt_d = WIN_LAST;
    end else if (win_cnt_q != '0) begin
      win_cnt_d = win_cnt_q - WW'(1);
    end

    req             = '0;
    req[PEND_CLR]   = clr_req_in;
    req[PEND_CFG]   = cfg_req_in && !play_in;
    req[PEND_LEVEL] = level_req_in;

    // Commands go out only in cycles that will not be part of a window.
    cmd_d = '0;
    if (!busy_d) begin
      if (pend_q[PEND_CLR])        cmd_d[PEND_CLR]   = 1'b1;
      else if (pend_q[PEND_CFG])   cmd_d[PEND_CFG]   = 1'b1;
      else if (pend_q[PEND_LEVEL]) cmd_d[PEND_LEVEL] = 1'b1;
    end

    pend_d = (pend_q & ~cmd_d) | req;

    err_d = cmd_d[PEND_CLR] ? 1'b0 : err_q;
    if (cfg_req_in && play_in) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      win_cnt_q <= '0;
      pend_q    <= '0;
      cmd_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      win_cnt_q <= win_cnt_d;
      pend_q    <= pend_d;
      cmd_q     <= cmd_d;
      err_q     <= err_d;
    end
  end

  assign cfg_out     = cmd_q[PEND_CFG];
  assign level_out   = cmd_q[PEND_LEVEL];
  assign clr_out     = cmd_q[PEND_CLR];
  assign busy_out    = busy_q;
  assign pending_out = pend_q;
  assign cfg_err_out = err_q;

endmodule

// File: tb/tb_dsp_scheduler.sv
// Directed bench for dsp_scheduler with DSP_LATENCY=4; pulses are viewed as {tick, clr, cfg, level}.
module tb_dsp_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        play_in;
  logic [31:0] cdiv_in;
  logic        cfg_req_in, level_req_in, clr_req_in;
  logic        tick_out, cfg_out, level_out, clr_out, busy_out, cfg_err_out;
  logic [2:0]  pending_out;

  int total = 0;
  int bad   = 0;
  int ntick;

  always #5 clk = ~clk;

  dsp_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .play_in     (play_in),
    .cdiv_in     (cdiv_in),
    .cfg_req_in  (cfg_req_in),
    .level_req_in(level_req_in),
    .clr_req_in  (clr_req_in),
    .tick_out    (tick_out),
    .cfg_out     (cfg_out),
    .level_out   (level_out),
    .clr_out     (clr_out),
    .busy_out    (busy_out),
    .pending_out (pending_out),
    .cfg_err_out (cfg_err_out)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pulses();
    return {tick_out, clr_out, cfg_out, level_out};
  endfunction

  initial begin
    // Reset held two cycles with every input asserted
    rst = 1'b1; play_in = 1'b1; cdiv_in = 32'd10;
    cfg_req_in = 1'b1; level_req_in = 1'b1; clr_req_in = 1'b1;
    cyc(); cyc();
    chk("rst_pulses", 32'(pulses()), 32'h0);
    chk("rst_busy", 32'(busy_out), 32'h0);
    chk("rst_pending", 32'(pending_out), 32'h0);
    chk("rst_err", 32'(cfg_err_out), 32'h0);
    rst = 1'b0; play_in = 1'b0;
    cfg_req_in = 1'b0; level_req_in = 1'b0; clr_req_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("quiet_after_rst", 32'({pulses(), pending_out, busy_out}), 32'h0);
    end

    // Divider 10, play held 52 cycles: ticks at 10,20,30,40,50
    cdiv_in = 32'd10; play_in = 1'b1; ntick = 0;
    for (int c = 0; c < 62; c++) begin
      cyc();
      chk("div10_tick", 32'(tick_out), 32'((c >= 10 && c <= 50 && c % 10 == 0) ? 1 : 0));
      chk("div10_busy", 32'(busy_out), 32'((c >= 10 && c <= 54 && c % 10 < 5) ? 1 : 0));
      if (tick_out) ntick++;
      if (c == 51) play_in = 1'b0;
    end
    chk("div10_count", 32'(ntick), 32'd5);

    // Divider 3 clamps to 6; switching to 12 mid-period affects the period after next tick
    cdiv_in = 32'd3; play_in = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      cyc();
      chk("clamp_tick", 32'(tick_out), 32'((c == 6 || c == 12 || c == 24 || c == 36) ? 1 : 0));
      if (c == 8) cdiv_in = 32'd12;
    end
    play_in = 1'b0;
    repeat (6) cyc();

    // clr+level requested in the tick cycle drain after the window, clr first
    cdiv_in = 32'd10; play_in = 1'b1;
    for (int c = 0; c <= 17; c++) begin
      cyc();
      case (c)
        10: begin
          chk("win_tick", 32'(tick_out), 32'h1);
          clr_req_in = 1'b1; level_req_in = 1'b1;
        end
        11: begin
          clr_req_in = 1'b0; level_req_in = 1'b0;
          chk("win_pend", 32'(pending_out), 32'b101);
          chk("win_hold", 32'(pulses()), 32'h0);
        end
        14: chk("win_busy_last", 32'(busy_out), 32'h1);
        15: begin
          chk("win_busy_off", 32'(busy_out), 32'h0);
          chk("win_clr", 32'(pulses()), 32'b0100);
          chk("win_pend_clr", 32'(pending_out), 32'b001);
        end
        16: begin
          chk("win_level", 32'(pulses()), 32'b0001);
          chk("win_pend_lvl", 32'(pending_out), 32'b000);
        end
        17: begin
          chk("win_after", 32'({pulses(), pending_out}), 32'h0);
          play_in = 1'b0;
        end
        default: ;
      endcase
    end
    repeat (4) cyc();

    // cfg while playing is rejected; clr clears the error
    cdiv_in = 32'd10; play_in = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      cyc();
      case (c)
        0: cfg_req_in = 1'b1;
        1: begin
          cfg_req_in = 1'b0;
          chk("err_set", 32'(cfg_err_out), 32'h1);
          chk("err_nopend", 32'(pending_out), 32'h0);
          chk("err_nocfg1", 32'(pulses()), 32'h0);
        end
        2: begin
          chk("err_nocfg2", 32'(pulses()), 32'h0);
          clr_req_in = 1'b1;
        end
        3: begin
          clr_req_in = 1'b0;
          chk("err_clr_pend", 32'(pending_out), 32'b100);
          chk("err_still", 32'(cfg_err_out), 32'h1);
        end
        4: chk("err_clr_pulse", 32'(pulses()), 32'b0100);
        5: begin
          chk("err_cleared", 32'(cfg_err_out), 32'h0);
          chk("err_quiet", 32'(pulses()), 32'h0);
        end
        6: play_in = 1'b0;
        default: ;
      endcase
    end
    repeat (3) cyc();

    // Stopped: priority, merge of a repeated request, re-set on the issue cycle
    for (int d = 0; d <= 6; d++) begin
      cyc();
      case (d)
        0: begin
          clr_req_in = 1'b1; cfg_req_in = 1'b1; level_req_in = 1'b1;
        end
        1: begin
          clr_req_in = 1'b0; cfg_req_in = 1'b0;
          chk("pri_pend_all", 32'(pending_out), 32'b111);
          chk("pri_wait", 32'(pulses()), 32'h0);
        end
        2: begin
          level_req_in = 1'b0;
          chk("pri_clr", 32'(pulses()), 32'b0100);
          chk("pri_pend2", 32'(pending_out), 32'b011);
          cfg_req_in = 1'b1;
        end
        3: begin
          cfg_req_in = 1'b0;
          chk("pri_cfg", 32'(pulses()), 32'b0010);
          chk("pri_reset_bit", 32'(pending_out), 32'b011);
        end
        4: begin
          chk("pri_cfg_again", 32'(pulses()), 32'b0010);
          chk("pri_pend4", 32'(pending_out), 32'b001);
        end
        5: begin
          chk("pri_level", 32'(pulses()), 32'b0001);
          chk("pri_pend5", 32'(pending_out), 32'b000);
        end
        6: begin
          chk("pri_merged", 32'(pulses()), 32'h0);
          chk("pri_no_err", 32'(cfg_err_out), 32'h0);
        end
        default: ;
      endcase
    end

    // Reset in the 2nd window cycle discards pending cfg/level
    cdiv_in = 32'd10; play_in = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      cyc();
      if (c == 10) begin
        chk("mrst_tick", 32'(tick_out), 32'h1);
        play_in = 1'b0; cfg_req_in = 1'b1; level_req_in = 1'b1;
      end else if (c == 11) begin
        cfg_req_in = 1'b0; level_req_in = 1'b0;
        chk("mrst_pend", 32'(pending_out), 32'b011);
        chk("mrst_busy", 32'(busy_out), 32'h1);
        rst = 1'b1;
      end else if (c == 12) begin
        rst = 1'b0;
        chk("mrst_out", 32'({pulses(), pending_out, busy_out, cfg_err_out}), 32'h0);
      end else if (c > 12) begin
        chk("mrst_quiet", 32'({pulses(), pending_out, busy_out}), 32'h0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
